// File: rtl/tt_um_hoene_frame_controller_pkg.sv
// Shared definitions for the smart-LED receive-path frame controller.
package tt_um_hoene_frame_controller_pkg;

   // Frame sequencing states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RECEIVE = 2'd1,
      ST_FORWARD = 2'd2,
      ST_ERROR   = 2'd3
   } state_t;

   // Default geometry: RGB 8:8:8 colour word, 64-clock inter-frame gap
   localparam int DEF_DATA_BITS   = 24;
   localparam int DEF_IDLE_CYCLES = 64;
   localparam int DEF_CNT_W       = 7;

endpackage

// File: rtl/tt_um_hoene_idle_timer.sv
// Saturating idle counter: cleared by each bit event, flags the end of a frame
// when IDLE_CYCLES clocks have passed without one.
module tt_um_hoene_idle_timer #(
   parameter int CNT_W       = 7,
   parameter int IDLE_CYCLES = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic timeout
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(IDLE_CYCLES);

   logic [CNT_W-1:0] count_reg;

   // Count bit-free clocks, holding at IDLE_CYCLES so the timeout fires once
   always_ff @(posedge clk) begin
      if (rst)
         count_reg <= '0;
      else if (clear)
         count_reg <= '0;
      else if (count_reg != CNT_SAT)
         count_reg <= count_reg + 1'b1;
   end

   // A bit event in the same cycle always cancels the timeout
   assign timeout = (count_reg == CNT_LAST) && !clear;

endmodule

// File: rtl/tt_um_hoene_frame_controller.sv
// Frames the decoded bit stream of one smart LED: keeps the first DATA_BITS
// bits as the local colour and forwards the rest down the chain.
module tt_um_hoene_frame_controller
   import tt_um_hoene_frame_controller_pkg::*;
#(
   parameter int DATA_BITS   = DEF_DATA_BITS,
   parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 dec_data,
   input  logic                 dec_clk,
   input  logic                 dec_error,
   output logic [DATA_BITS-1:0] color,
   output logic                 color_valid,
   output logic                 fwd_enable,
   output logic                 fwd_data,
   output logic                 fwd_strobe,
   output logic                 busy,
   output logic                 frame_error
);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0] ALL_BITS = CNT_W'(DATA_BITS);

   state_t                 state_reg, state_next;
   logic                   dec_clk_q;
   logic [DATA_BITS-2:0]   shadow_reg, shadow_next;
   logic [CNT_W-1:0]       bit_cnt_reg, bit_cnt_next;
   logic [DATA_BITS-1:0]   color_reg, color_next;
   logic                   color_valid_reg, color_valid_next;
   logic                   fwd_enable_reg, fwd_enable_next;
   logic                   fwd_data_reg, fwd_data_next;
   logic                   fwd_strobe_reg, fwd_strobe_next;
   logic                   busy_reg, busy_next;
   logic                   frame_error_reg, frame_error_next;
   logic                   bit_event;
   logic                   timeout;

   assign bit_event = dec_clk & ~dec_clk_q;

   tt_um_hoene_idle_timer #(
      .CNT_W       (CNT_W),
      .IDLE_CYCLES (IDLE_CYCLES)
   ) u_idle_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (bit_event),
      .timeout (timeout)
   );

   // State, datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         dec_clk_q       <= 1'b0;
         shadow_reg      <= '0;
         bit_cnt_reg     <= '0;
         color_reg       <= '0;
         color_valid_reg <= 1'b0;
         fwd_enable_reg  <= 1'b0;
         fwd_data_reg    <= 1'b0;
         fwd_strobe_reg  <= 1'b0;
         busy_reg        <= 1'b0;
         frame_error_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         dec_clk_q       <= dec_clk;
         shadow_reg      <= shadow_next;
         bit_cnt_reg     <= bit_cnt_next;
         color_reg       <= color_next;
         color_valid_reg <= color_valid_next;
         fwd_enable_reg  <= fwd_enable_next;
         fwd_data_reg    <= fwd_data_next;
         fwd_strobe_reg  <= fwd_strobe_next;
         busy_reg        <= busy_next;
         frame_error_reg <= frame_error_next;
      end
   end

   // Next-state logic; decoder error outranks a bit event, which outranks timeout
   always_comb begin
      state_next       = state_reg;
      shadow_next      = shadow_reg;
      bit_cnt_next     = bit_cnt_reg;
      color_next       = color_reg;
      color_valid_next = 1'b0;
      fwd_data_next    = fwd_data_reg;
      fwd_strobe_next  = 1'b0;
      frame_error_next = frame_error_reg;

      case (state_reg)
         ST_IDLE: begin
            // dec_error is meaningless between frames and is ignored here
            if (bit_event) begin
               shadow_next      = {{(DATA_BITS-2){1'b0}}, dec_data};
               bit_cnt_next     = CNT_W'(1);
               frame_error_next = 1'b0;
               state_next       = ST_RECEIVE;
            end
         end
         ST_RECEIVE: begin
            if (dec_error) begin
               shadow_next      = '0;
               bit_cnt_next     = '0;
               frame_error_next = 1'b1;
               state_next       = ST_ERROR;
            end else if (bit_event) begin
               if (bit_cnt_reg == LAST_BIT) begin
                  color_next       = {shadow_reg, dec_data};
                  color_valid_next = 1'b1;
                  bit_cnt_next     = ALL_BITS;
                  state_next       = ST_FORWARD;
               end else begin
                  shadow_next  = {shadow_reg[DATA_BITS-3:0], dec_data};
                  bit_cnt_next = bit_cnt_reg + 1'b1;
               end
            end else if (timeout) begin
               // Truncated frame: drop the partial word, keep the old colour
               shadow_next      = '0;
               bit_cnt_next     = '0;
               frame_error_next = 1'b1;
               state_next       = ST_IDLE;
            end
         end
         ST_FORWARD: begin
            if (dec_error) begin
               shadow_next      = '0;
               bit_cnt_next     = '0;
               frame_error_next = 1'b1;
               state_next       = ST_ERROR;
            end else if (bit_event) begin
               fwd_data_next   = dec_data;
               fwd_strobe_next = 1'b1;
            end else if (timeout) begin
               bit_cnt_next = '0;
               state_next   = ST_IDLE;
            end
         end
         default: begin
            // ST_ERROR: swallow the rest of the frame until the line goes quiet
            if (timeout)
               state_next = ST_IDLE;
         end
      endcase

      fwd_enable_next = (state_next == ST_FORWARD);
      busy_next       = (state_next != ST_IDLE);
   end

   assign color       = color_reg;
   assign color_valid = color_valid_reg;
   assign fwd_enable  = fwd_enable_reg;
   assign fwd_data    = fwd_data_reg;
   assign fwd_strobe  = fwd_strobe_reg;
   assign busy        = busy_reg;
   assign frame_error = frame_error_reg;

endmodule

// File: tb/tb_tt_um_hoene_frame_controller.sv
// Self-checking bench for the frame controller: table of frames plus
// hand-written reset sequences, with queue scoreboards for colour and forwarded bits.
module tb_tt_um_hoene_frame_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        dec_data;
   logic        dec_clk;
   logic        dec_error;
   logic [23:0] color;
   logic        color_valid;
   logic        fwd_enable;
   logic        fwd_data;
   logic        fwd_strobe;
   logic        busy;
   logic        frame_error;

   int n_pass  = 0;
   int n_total = 0;

   logic [23:0] color_q[$];
   logic        fwd_q[$];
   logic [23:0] mon_color_exp;
   logic        mon_fwd_exp;

   typedef struct {
      logic [31:0] data;       // frame bits, right-aligned, sent MSB first
      int          nbits;
      int          err_at;     // bit index where dec_error rises, -1 for none
      logic [23:0] exp_color;  // colour after the frame has ended
      bit          exp_valid;  // frame completes a colour word
      bit          exp_ferr;   // frame_error after the frame has ended
   } vec_t;

   vec_t vecs[6];

   tt_um_hoene_frame_controller dut (
      .clk         (clk),
      .rst         (rst),
      .dec_data    (dec_data),
      .dec_clk     (dec_clk),
      .dec_error   (dec_error),
      .color       (color),
      .color_valid (color_valid),
      .fwd_enable  (fwd_enable),
      .fwd_data    (fwd_data),
      .fwd_strobe  (fwd_strobe),
      .busy        (busy),
      .frame_error (frame_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Scoreboard: every output pulse must match the next queued expectation
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (color_valid) begin
            if (color_q.size() == 0) check("unexpected_color_valid", color_valid, 0);
            else begin
               mon_color_exp = color_q.pop_front();
               check("color_on_valid", color, mon_color_exp);
            end
         end
         if (fwd_strobe) begin
            if (fwd_q.size() == 0) check("unexpected_fwd_strobe", fwd_strobe, 0);
            else begin
               mon_fwd_exp = fwd_q.pop_front();
               check("fwd_data", fwd_data, mon_fwd_exp);
            end
         end
      end
   end

   // One bit cell: dec_clk high 4 clk, low 4 clk; inputs change on negedge
   task automatic send_frame(input logic [31:0] data, input int nbits, input int err_at,
                             input bit exp_valid);
      logic b;
      if (exp_valid) color_q.push_back(data[nbits-1 -: 24]);
      for (int i = 0; i < nbits; i++) begin
         b = data[nbits-1-i];
         if (i == err_at) dec_error = 1'b1;
         if (i >= 24 && (err_at < 0 || i < err_at)) fwd_q.push_back(b);
         dec_data = b;
         dec_clk  = 1'b1;
         @(negedge clk);
         if (i == 0) begin
            check("busy_at_first_bit", busy, 1);
            check("ferr_cleared_at_first_bit", frame_error, 0);
         end
         if (i == 23 && exp_valid) begin
            check("color_valid_latency", color_valid, 1);
            check("fwd_enable_after_word", fwd_enable, 1);
         end
         repeat (3) @(negedge clk);
         dec_clk = 1'b0;
         repeat (4) @(negedge clk);
      end
      dec_error = 1'b0;
   endtask

   task automatic idle_gap();
      repeat (70) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{32'h00A55A3C, 24, -1, 24'hA55A3C, 1'b1, 1'b0};
      vecs[1] = '{32'hA55A3C81, 32, -1, 24'hA55A3C, 1'b1, 1'b0};
      vecs[2] = '{32'h00005A5A, 15, 10, 24'hA55A3C, 1'b0, 1'b1};
      vecs[3] = '{32'h00123456, 24, -1, 24'h123456, 1'b1, 1'b0};
      vecs[4] = '{32'h00000ABC, 12, -1, 24'h123456, 1'b0, 1'b1};
      vecs[5] = '{32'h0FFFFFF5, 28, 26, 24'hFFFFFF, 1'b1, 1'b1};

      rst = 1'b1; dec_data = 1'b0; dec_clk = 1'b0; dec_error = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_color", color, 0);
      check("rst_color_valid", color_valid, 0);
      check("rst_fwd_enable", fwd_enable, 0);
      check("rst_fwd_strobe", fwd_strobe, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_error", frame_error, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      for (int v = 0; v < 6; v++) begin
         send_frame(vecs[v].data, vecs[v].nbits, vecs[v].err_at, vecs[v].exp_valid);
         idle_gap();
         check($sformatf("v%0d_color", v), color, vecs[v].exp_color);
         check($sformatf("v%0d_frame_error", v), frame_error, vecs[v].exp_ferr);
         check($sformatf("v%0d_busy_idle", v), busy, 0);
         check($sformatf("v%0d_fwd_enable_idle", v), fwd_enable, 0);
         $display("frame %0d: data=0x%0h bits=%0d err_at=%0d color=0x%06h ferr=%0b",
                  v, vecs[v].data, vecs[v].nbits, vecs[v].err_at, color, frame_error);
      end

      // Reset in the middle of a frame aborts everything
      send_frame(32'h000ABCDE, 20, -1, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_color", color, 0);
      check("midrst_busy", busy, 0);
      check("midrst_fwd_enable", fwd_enable, 0);
      check("midrst_frame_error", frame_error, 0);
      check("midrst_color_valid", color_valid, 0);
      rst = 1'b0;
      @(negedge clk);
      send_frame(32'h0000FF00, 24, -1, 1'b1);
      idle_gap();
      check("post_rst_color", color, 24'h00FF00);
      check("post_rst_frame_error", frame_error, 0);
      $display("post-reset frame: color=0x%06h", color);

      check("color_queue_drained", color_q.size(), 0);
      check("fwd_queue_drained", fwd_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
